// File: rtl/alu_pkg.sv
// ALU shared definitions: operation select encodings, datapath width, sequencer states.
// Latency: n/a (constants only).
// Backpressure: n/a.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_CMP = 3'b101;

    // Multi-cycle unit states, kept as plain constants so they drop into legacy code.
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

endpackage

// File: rtl/sub_chunk.sv
// One W-bit slice of the ripple subtractor: sum = a + b_inv + cin.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module sub_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b_inv,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b_inv} + {{W{1'b0}}, cin};

endmodule

// File: rtl/sub_seq.sv
// Sequential 32-bit subtract/compare: opA - opB as opA + ~opB + 1, one CHUNK slice per clock.
// Latency: done pulses WIDTH/CHUNK cycles after start is accepted; optional CMP via SUB_SEQ_CMP_EN.
// Backpressure: start is only sampled in IDLE; requests while busy or with unsupported sel are dropped.
module sub_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             elk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             z,
    output logic             c,
    output logic             v
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

    logic [0:0]       state;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic             a_msb;
    logic             b_msb;
    logic             cmp_q;

    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;
    logic [WIDTH-1:0] full;
    logic             accept;

    // Operands shift right each cycle, so the active slice always sits in the low bits
    // and a single adder slice is reused for every chunk.
    sub_chunk #(.W(CHUNK)) u_chunk (
        .a     (a_q[CHUNK-1:0]),
        .b_inv (b_q[CHUNK-1:0]),
        .cin   (carry),
        .sum   (slice_sum),
        .cout  (slice_cout)
    );

    // The accumulator fills from the top; on the last slice this is the complete difference.
    assign full = {slice_sum, acc[WIDTH-1:CHUNK]};
    assign busy = (state == S_BUSY);

    // Decide whether a start request names an operation this unit handles.
    always_comb begin
        accept = 1'b0;
`ifdef SUB_SEQ_CMP_EN
        accept = start && ((sel == ALU_SUB) || (sel == ALU_CMP));
`else
        accept = start && (sel == ALU_SUB);
`endif
    end

    // Sequencer: latch operands on accept, then ripple one slice per cycle and publish flags.
    always_ff @(posedge elk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            k     <= '0;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            cmp_q <= 1'b0;
            done  <= 1'b0;
            res   <= '0;
            z     <= 1'b0;
            c     <= 1'b0;
            v     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state <= S_BUSY;
                        a_q   <= opA;
                        b_q   <= ~opB;
                        carry <= 1'b1;
                        k     <= '0;
                        a_msb <= opA[WIDTH-1];
                        b_msb <= opB[WIDTH-1];
                        cmp_q <= (sel == ALU_CMP);
                    end
                end
                S_BUSY: begin
                    a_q   <= {{CHUNK{1'b0}}, a_q[WIDTH-1:CHUNK]};
                    b_q   <= {{CHUNK{1'b0}}, b_q[WIDTH-1:CHUNK]};
                    acc   <= full;
                    carry <= slice_cout;
                    k     <= k + 1'b1;
                    if (k == K_LAST) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                        z     <= (full == '0);
                        c     <= slice_cout;
                        v     <= (a_msb != b_msb) && (full[WIDTH-1] != a_msb);
                        // A compare only refreshes the flags; res keeps the last SUB result.
                        if (!cmp_q) begin
                            res <= full;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_seq.sv
// Directed bench for sub_seq: hand-computed vectors, immediate assertions per check.
// Latency: checks busy for 4 cycles then the done pulse for each accepted operation.
// Backpressure: exercises dropped starts (busy, ADD, CMP when disabled) and mid-operation reset.
module tb_sub_seq;
    import alu_pkg::*;

    logic        elk;
    logic        rst_n;
    logic        start;
    logic [2:0]  sel;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        busy;
    logic        done;
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;

    int n_cmp = 0;
    int n_err = 0;

    sub_seq #(.WIDTH(32), .CHUNK(8)) dut (
        .elk   (elk),
        .rst_n (rst_n),
        .start (start),
        .sel   (sel),
        .opA   (opA),
        .opB   (opB),
        .busy  (busy),
        .done  (done),
        .res   (res),
        .z     (z),
        .c     (c),
        .v     (v)
    );

    initial elk = 1'b0;
    always #5 elk = ~elk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] e_res,
                           input logic e_z, input logic e_c, input logic e_v);
        chk({tag, ".res"}, res, e_res);
        chk({tag, ".z"}, {31'd0, z}, {31'd0, e_z});
        chk({tag, ".c"}, {31'd0, c}, {31'd0, e_c});
        chk({tag, ".v"}, {31'd0, v}, {31'd0, e_v});
    endtask

    // Drive a request at the current time (a negedge); hold it through one rising edge.
    task automatic issue(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        sel   = s;
        opA   = a;
        opB   = b;
        @(posedge elk);
        #1;
        start = 1'b0;
        opA   = 32'hDEAD_BEEF;
        opB   = 32'h0BAD_F00D;
    endtask

    // Expect 4 busy cycles, then a done cycle with busy low. Returns at the done-cycle negedge.
    task automatic expect_run(input string tag);
        for (int i = 0; i < 4; i++) begin
            @(negedge elk);
            chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
            chk({tag, ".nodone"}, {31'd0, done}, 32'd0);
        end
        @(negedge elk);
        chk({tag, ".done"}, {31'd0, done}, 32'd1);
        chk({tag, ".busy_lo"}, {31'd0, busy}, 32'd0);
    endtask

    // Expect the unit to stay idle for n cycles.
    task automatic expect_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge elk);
            chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
            chk({tag, ".done"}, {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        sel   = ALU_ADD;
        opA   = '0;
        opB   = '0;
        repeat (2) @(negedge elk);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk_out("rst", 32'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge elk);

        // 7 - 2
        issue(ALU_SUB, 32'd7, 32'd2);
        expect_run("sub7_2");
        chk_out("sub7_2", 32'd5, 1'b0, 1'b1, 1'b0);
        @(negedge elk);
        chk("sub7_2.pulse", {31'd0, done}, 32'd0);

        // CMP 3 vs 9 with res = 5
        issue(ALU_CMP, 32'd3, 32'd9);
`ifdef SUB_SEQ_CMP_EN
        expect_run("cmp3_9");
        chk_out("cmp3_9", 32'd5, 1'b0, 1'b0, 1'b0);
`else
        expect_idle("cmp3_9", 5);
        chk_out("cmp3_9", 32'd5, 1'b0, 1'b1, 1'b0);
`endif
        @(negedge elk);

        // 2 - 7
        issue(ALU_SUB, 32'd2, 32'd7);
        expect_run("sub2_7");
        chk_out("sub2_7", 32'hFFFF_FFFB, 1'b0, 1'b0, 1'b0);
        @(negedge elk);

        // 0x80000000 - 1 then 5 - 5 issued in the done cycle
        issue(ALU_SUB, 32'h8000_0000, 32'd1);
        expect_run("sub_ovf");
        chk_out("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
        issue(ALU_SUB, 32'd5, 32'd5);
        expect_run("sub5_5");
        chk_out("sub5_5", 32'd0, 1'b1, 1'b1, 1'b0);
        @(negedge elk);

        // 10 - 3 with a second start during BUSY
        issue(ALU_SUB, 32'd10, 32'd3);
        @(negedge elk);
        chk("drop.busy0", {31'd0, busy}, 32'd1);
        issue(ALU_SUB, 32'd100, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge elk);
            chk("drop.busy", {31'd0, busy}, 32'd1);
        end
        @(negedge elk);
        chk("drop.done", {31'd0, done}, 32'd1);
        chk_out("drop", 32'd7, 1'b0, 1'b1, 1'b0);
        expect_idle("drop.after", 5);

        // ADD is not handled here
        issue(ALU_ADD, 32'd1, 32'd1);
        expect_idle("add", 5);
        chk_out("add", 32'd7, 1'b0, 1'b1, 1'b0);
        @(negedge elk);

        // Reset during the second BUSY cycle
        issue(ALU_SUB, 32'h1234_5678, 32'd1);
        @(negedge elk);
        chk("rstmid.busy1", {31'd0, busy}, 32'd1);
        @(negedge elk);
        rst_n = 1'b0;
        #1;
        chk("rstmid.busy", {31'd0, busy}, 32'd0);
        chk("rstmid.done", {31'd0, done}, 32'd0);
        chk_out("rstmid", 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge elk);
        rst_n = 1'b1;
        expect_idle("rstmid.after", 6);
        chk_out("rstmid.after", 32'd0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
